// File: rtl/addsub_stage.sv
// Two-stage add/sub/compare pipeline with valid/ready handshakes on both sides.
// S1 registers prepared operands; S2 registers the result and adder flags.
module addsub_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SLT  = 2'b10,
    OP_SLTU = 2'b11
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;

  logic             s2_advance;
  logic             accept;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;
  logic [WIDTH-1:0] result_nxt;

  // in_ready depends only on pipeline state, out_ready and flush
  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !flush && (!s1_valid || s2_advance);
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Subtract-style ops feed the adder with inverted b and a carry-in of one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op  <= OP_ADD;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_cin <= 1'b0;
    end else if (accept) begin
      s1_op <= op_e'(in_op);
      s1_a  <= in_a;
      if (op_e'(in_op) == OP_ADD) begin
        s1_b   <= in_b;
        s1_cin <= 1'b0;
      end else begin
        s1_b   <= ~in_b;
        s1_cin <= 1'b1;
      end
    end
  end

  always_comb begin
    sum_ext = {1'b0, s1_a} + {1'b0, s1_b} + (WIDTH+1)'(s1_cin);
    sum     = sum_ext[WIDTH-1:0];
    carry   = sum_ext[WIDTH];
    ovf     = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
    case (s1_op)
      OP_SLT:  result_nxt = WIDTH'(sum[MSB] ^ ovf);
      OP_SLTU: result_nxt = WIDTH'(!carry);
      default: result_nxt = sum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
    end
  end

  // Result and flags only move when a valid S1 entry transfers into S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_z      <= 1'b0;
      out_n      <= 1'b0;
      out_c      <= 1'b0;
      out_v      <= 1'b0;
    end else if (s2_advance && s1_valid && !flush) begin
      out_result <= result_nxt;
      out_z      <= (sum == '0);
      out_n      <= sum[MSB];
      out_c      <= carry;
      out_v      <= ovf;
    end
  end

endmodule
